uart_loader: RTL and testbench
==============================

# uart_loader

Program-load front end for the instruction memory. It receives a UART 8N1 byte stream on `rxd` and parses a 4-byte big-endian instruction-count header. It then forwards the following count×4 payload bytes to the instruction memory's loader port as `loader_data`, `loader_enable` and `loader_ready`. Enable/ready sequencing is generated so the memory's byte-assembly FSM commits every word, including the last.

## Interface
- `CLK_PER_BIT`, 868: clock cycles per UART bit; must be ≥ 8.
- `INST_MEM_WIDTH`, 2: address width of the instruction memory; maximum accepted count is 2**INST_MEM_WIDTH.
- `CLK`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  UART serial input, idle high, asynchronous to `CLK`.
- `loader_data`  out  8  current payload byte; valid while `loader_ready` is high, held until the next byte.
- `loader_ready`  out  1  one-cycle pulse per payload byte.
- `loader_enable`  out  1  high for the whole payload transfer window.
- `load_done`  out  1  sticky; set when all payload bytes have been delivered and the drain has completed.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `len_err`  out  1  sticky; header count exceeded 2**INST_MEM_WIDTH.

## Operation
- Reset (asserted): all outputs are 0. The synchronizer flops are set to 1, the RX FSM goes to IDLE, the loader FSM goes to HDR, and the header/byte counters are cleared. Reset taking effect mid-transfer drops `loader_enable` immediately.
- RX front end: `rxd` passes through a 2-flop synchronizer. RX FSM:
  - IDLE: waits for the synchronized line to go low.
  - START: waits CLK_PER_BIT/2 cycles and resamples. If low, goes to DATA; if high, the start was false and it returns to IDLE.
  - DATA: samples 8 bits at bit centres (every CLK_PER_BIT cycles), LSB first.
  - STOP: samples once. If high, `byte_valid` pulses for 1 cycle. If low, it sets `frame_err`, drops the byte, and returns to IDLE.
- Loader FSM:
  - HDR: collects 4 valid bytes into `count[31:0]`, MSB first.
    - On the 4th byte: count == 0 → DONE.
    - count > 2**INST_MEM_WIDTH → ERR, and `len_err` is set.
    - Otherwise → STREAM, with `loader_enable` set on the next edge.
  - STREAM: each `byte_valid` loads `loader_data` with the byte, pulses `loader_ready` and increments the byte counter (width INST_MEM_WIDTH+3). When the counter reaches count×4, the FSM goes to DRAIN.
  - DRAIN: holds `loader_enable` high for exactly 2 cycles after the final `loader_ready` pulse, then goes to DONE.
  - DONE: `loader_enable` = 0 and `load_done` = 1. Further RX bytes are ignored. The only exit is reset.
  - ERR: `loader_enable` = 0 and `load_done` stays 0. Further RX bytes are ignored. The only exit is reset.
- Any framing error while in HDR, STREAM or DRAIN moves the FSM to ERR. `loader_enable` falls on the next edge, which aborts the memory load and resets the memory's write index.
- Byte-order rule: the first payload byte is the instruction's bits [31:24].

## Timing
- Synchronizer latency: 2 cycles.
- `byte_valid` follows the stop-bit sample edge by 1 cycle. `loader_ready` and `loader_data` update on the edge after `byte_valid`.
- Stop-bit sample point: (2 + CLK_PER_BIT/2 + 9×CLK_PER_BIT) cycles after the synchronized falling edge, ±1 cycle.
- `loader_enable` rises 1 cycle after the 4th header `byte_valid`. The first `loader_ready` therefore comes at least CLK_PER_BIT×10 cycles later, which satisfies the memory's requirement that enable precede ready by at least 1 cycle.
- Consecutive `loader_ready` pulses are at least 10×CLK_PER_BIT cycles apart. `loader_ready` is never high on two consecutive cycles.
- `loader_enable` falls exactly 3 cycles after the final `loader_ready` cycle (ready at T; enable high at T+1 and T+2; low at T+3). `load_done` rises in the same cycle that `loader_enable` falls.
- Back-to-back frames: a start bit immediately following a stop bit must be received without loss.

## Test plan
- CLK_PER_BIT=16, INST_MEM_WIDTH=2. Send header 00 00 00 02, then 12 34 56 78 9A BC DE F0 → 8 `loader_ready` pulses carrying those bytes in order. Enable rises after byte 4 of the header and falls 3 cycles after the last ready. `load_done`=1, both error flags 0.
- Header 00 00 00 00 → `loader_enable` never rises, `load_done`=1 after the 4th byte, no `loader_ready`.
- Header 00 00 00 05 (>4) → `len_err`=1 and enable never rises. A subsequent payload produces no `loader_ready`, and `load_done` stays 0.
- Header 00 00 00 01, then payload byte AA sent with stop bit 0 → `frame_err`=1, no `loader_ready` for AA, enable falls 1 cycle after the error, `load_done` stays 0.
- 0.25-bit low glitch on `rxd` in IDLE → no byte, no error. A later valid header 00 00 00 01 plus 4 bytes loads normally.
- Assert `reset` low during the 3rd payload byte of a count=1 load → all outputs are 0 immediately. A full header 00 00 00 01 plus 4 bytes after release completes with `load_done`=1.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: UART 8N1 receiver feeding the instruction-memory loader port.
// A 4-byte big-endian header gives the instruction count. The count*4 payload
// bytes that follow are forwarded with enable/ready sequencing. Enable is held
// for a short drain after the last byte so the memory commits the final word.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RX_IDLE   | line idle, waiting for a synchronized low
// RX_START  | half-bit wait, then confirm the start bit
// RX_DATA   | sample 8 data bits at bit centres, LSB first
// RX_STOP   | sample the stop bit: high -> byte_valid, low -> framing error
// LD_HDR    | collect the 4 header bytes, MSB first
// LD_STREAM | forward payload bytes as loader_ready pulses
// LD_DRAIN  | hold loader_enable for 2 cycles after the final ready
// LD_DONE   | load complete; RX bytes ignored until reset
// LD_ERR    | length or framing error; RX bytes ignored until reset
module uart_loader #(
  parameter int CLK_PER_BIT    = 868,
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] loader_data,
  output logic       loader_ready,
  output logic       loader_enable,
  output logic       load_done,
  output logic       frame_err,
  output logic       len_err
);

  localparam int TW  = $clog2(CLK_PER_BIT);
  localparam int BCW = INST_MEM_WIDTH + 3;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [31:0]   MAX_COUNT = 32'd1 << INST_MEM_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {LD_HDR, LD_STREAM, LD_DRAIN, LD_DONE, LD_ERR} ld_state_e;

  logic            rxd_s1_q, rxd_s2_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            ferr_pulse_q, ferr_pulse_d;
  logic            frame_err_q;

  ld_state_e       ld_state_q, ld_state_d;
  logic [23:0]     hdr_q, hdr_d;
  logic [1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [INST_MEM_WIDTH:0] count_q, count_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]      drain_q, drain_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            enable_q, enable_d;
  logic            done_q, done_d;
  logic            len_err_q, len_err_d;

  logic [31:0]     hdr_next;
  logic [BCW-1:0]  byte_target;
  logic [BCW-1:0]  byte_cnt_inc;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // RX FSM state and datapath registers; frame_err is sticky.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      tmr_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      ferr_pulse_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      tmr_q        <= tmr_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ferr_pulse_q <= ferr_pulse_d;
      frame_err_q  <= frame_err_q | ferr_pulse_d;
    end
  end

  // RX next-state: down-counting bit timer, terminal count at zero.
  always_comb begin
    rx_state_d   = rx_state_q;
    tmr_d        = tmr_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    ferr_pulse_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxd_s2_q) begin
          rx_state_d = RX_START;
          tmr_d      = HALF_LAST;
        end
      end
      RX_START: begin
        if (tmr_q == '0) begin
          if (!rxd_s2_q) begin
            rx_state_d = RX_DATA;
            tmr_d      = BIT_LAST;
            bit_idx_d  = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (tmr_q == '0) begin
          shift_d = {rxd_s2_q, shift_q[7:1]};
          tmr_d   = BIT_LAST;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (tmr_q == '0) begin
          // Back to IDLE right at the stop-bit centre so a start bit that
          // follows immediately is still caught.
          if (rxd_s2_q) byte_valid_d = 1'b1;
          else          ferr_pulse_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign hdr_next     = {hdr_q, shift_q};
  assign byte_target  = {count_q, 2'b00};
  assign byte_cnt_inc = byte_cnt_q + 1'b1;

  // Loader FSM state and registered loader-port outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ld_state_q <= LD_HDR;
      hdr_q      <= '0;
      hdr_cnt_q  <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      drain_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      hdr_q      <= hdr_d;
      hdr_cnt_q  <= hdr_cnt_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      drain_q    <= drain_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      enable_q   <= enable_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
    end
  end

  // Loader next-state: header parse, payload stream, drain, terminal states.
  always_comb begin
    ld_state_d = ld_state_q;
    hdr_d      = hdr_q;
    hdr_cnt_d  = hdr_cnt_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    drain_d    = drain_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    enable_d   = enable_q;
    done_d     = done_q;
    len_err_d  = len_err_q;
    unique case (ld_state_q)
      LD_HDR: begin
        if (ferr_pulse_q) begin
          ld_state_d = LD_ERR;
        end else if (byte_valid_q) begin
          hdr_d     = {hdr_q[15:0], shift_q};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (hdr_next == 32'd0) begin
              ld_state_d = LD_DONE;
              done_d     = 1'b1;
            end else if (hdr_next > MAX_COUNT) begin
              ld_state_d = LD_ERR;
              len_err_d  = 1'b1;
            end else begin
              ld_state_d = LD_STREAM;
              count_d    = hdr_next[INST_MEM_WIDTH:0];
              byte_cnt_d = '0;
              enable_d   = 1'b1;
            end
          end
        end
      end
      LD_STREAM: begin
        if (ferr_pulse_q) begin
          ld_state_d = LD_ERR;
          enable_d   = 1'b0;
        end else if (byte_valid_q) begin
          data_d     = shift_q;
          ready_d    = 1'b1;
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_inc == byte_target) begin
            // Three cycles in DRAIN: enable drops on the 3rd edge after ready.
            ld_state_d = LD_DRAIN;
            drain_d    = 2'd2;
          end
        end
      end
      LD_DRAIN: begin
        if (ferr_pulse_q) begin
          ld_state_d = LD_ERR;
          enable_d   = 1'b0;
        end else if (drain_q == 2'd0) begin
          ld_state_d = LD_DONE;
          enable_d   = 1'b0;
          done_d     = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      LD_DONE: enable_d = 1'b0;
      LD_ERR:  enable_d = 1'b0;
      default: begin
        ld_state_d = LD_ERR;
        enable_d   = 1'b0;
      end
    endcase
  end

  assign loader_data   = data_q;
  assign loader_ready  = ready_q;
  assign loader_enable = enable_q;
  assign load_done     = done_q;
  assign frame_err     = frame_err_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench for uart_loader with CLK_PER_BIT=16.
module tb_uart_loader;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] loader_data;
  logic       loader_ready;
  logic       loader_enable;
  logic       load_done;
  logic       frame_err;
  logic       len_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  int cyc = 0;
  int n_ready, first_ready, last_ready, en_rise, en_fall, done_rise, ferr_rise;
  logic prev_ready, prev_en, prev_done, prev_ferr;

  uart_loader #(.CLK_PER_BIT(CPB), .INST_MEM_WIDTH(2)) dut (
    .CLK           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .loader_data   (loader_data),
    .loader_ready  (loader_ready),
    .loader_enable (loader_enable),
    .load_done     (load_done),
    .frame_err     (frame_err),
    .len_err       (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every ready pulse and logs edges.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      n_ready = 0; first_ready = -1; last_ready = -1;
      en_rise = -1; en_fall = -1; done_rise = -1; ferr_rise = -1;
      prev_ready = 0; prev_en = 0; prev_done = 0; prev_ferr = 0;
    end else begin
      if (loader_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: data %02h, no byte expected", loader_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (loader_data !== exp_b) begin
            errors++;
            $display("FAIL ready_data: got %02h, expected %02h", loader_data, exp_b);
          end
        end
        checks++;
        if (loader_enable !== 1'b1) begin
          errors++;
          $display("FAIL ready_with_enable: enable %b, expected 1", loader_enable);
        end
        checks++;
        if (prev_ready === 1'b1) begin
          errors++;
          $display("FAIL ready_consecutive: ready high on two cycles, expected single pulse");
        end
        n_ready++;
        if (first_ready < 0) first_ready = cyc;
        last_ready = cyc;
      end
      if (loader_enable && !prev_en) en_rise = cyc;
      if (!loader_enable && prev_en) en_fall = cyc;
      if (load_done && !prev_done) done_rise = cyc;
      if (frame_err && !prev_ferr) ferr_rise = cyc;
      prev_ready = loader_ready;
      prev_en    = loader_enable;
      prev_done  = load_done;
      prev_ferr  = frame_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop_bit;
    wait_cyc(CPB);
    rxd = 1'b1;
  endtask

  task automatic send_payload(input logic [7:0] b);
    exp_q.push_back(b);
    uart_send(b, 1'b1);
  endtask

  task automatic send_header(input logic [31:0] cnt);
    for (int i = 3; i >= 0; i--) uart_send(cnt[i*8 +: 8], 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rxd   = 1'b1;
    wait_cyc(3);
    checks++;
    if ({loader_data, loader_ready, loader_enable, load_done, frame_err, len_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data %02h rdy %b en %b done %b ferr %b lerr %b, expected all 0",
               loader_data, loader_ready, loader_enable, load_done, frame_err, len_err);
    end
    reset = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pl [8];
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    send_header(32'd2);
    checks++;
    if (loader_enable !== 1'b1) begin
      errors++;
      $display("FAIL b2b_enable_after_hdr: got %b, expected 1", loader_enable);
    end
    for (int i = 0; i < 8; i++) send_payload(pl[i]);
    wait_cyc(10);
    checks++;
    if (n_ready != 8) begin
      errors++;
      $display("FAIL b2b_ready_count: got %0d, expected 8", n_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_bytes_left: got %0d undelivered, expected 0", exp_q.size());
    end
    checks++;
    if (!(en_rise >= 0 && en_rise < first_ready)) begin
      errors++;
      $display("FAIL b2b_enable_before_ready: rise %0d first ready %0d, expected rise earlier", en_rise, first_ready);
    end
    checks++;
    if (en_fall - last_ready != 3) begin
      errors++;
      $display("FAIL b2b_enable_fall: got %0d cycles after last ready, expected 3", en_fall - last_ready);
    end
    checks++;
    if (done_rise != en_fall) begin
      errors++;
      $display("FAIL b2b_done_timing: done rise %0d enable fall %0d, expected equal", done_rise, en_fall);
    end
    checks++;
    if ({load_done, frame_err, len_err, loader_enable} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_final_flags: got done/ferr/lerr/en %b, expected 1000",
               {load_done, frame_err, len_err, loader_enable});
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_header(32'd0);
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: got %b, expected 1", load_done);
    end
    checks++;
    if (en_rise != -1 || n_ready != 0) begin
      errors++;
      $display("FAIL zero_no_transfer: enable rise %0d readies %0d, expected -1 and 0", en_rise, n_ready);
    end
  endtask

  task automatic test_len_err();
    do_reset();
    send_header(32'd5);
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_flag: got %b, expected 1", len_err);
    end
    for (int i = 0; i < 4; i++) uart_send(8'h11 * i[7:0], 1'b1);
    wait_cyc(5);
    checks++;
    if (en_rise != -1 || n_ready != 0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL len_err_ignored: enable rise %0d readies %0d done %b, expected -1 0 0",
               en_rise, n_ready, load_done);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_header(32'd1);
    checks++;
    if (loader_enable !== 1'b1) begin
      errors++;
      $display("FAIL ferr_enable_up: got %b, expected 1", loader_enable);
    end
    uart_send(8'hAA, 1'b0);
    wait_cyc(20);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_flag: got %b, expected 1", frame_err);
    end
    checks++;
    if (en_fall - ferr_rise != 1) begin
      errors++;
      $display("FAIL ferr_enable_fall: got %0d cycles after error, expected 1", en_fall - ferr_rise);
    end
    checks++;
    if (n_ready != 0 || load_done !== 1'b0 || loader_enable !== 1'b0) begin
      errors++;
      $display("FAIL ferr_aborted: readies %0d done %b en %b, expected 0 0 0", n_ready, load_done, loader_enable);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rxd = 1'b0;
    wait_cyc(CPB / 4);
    rxd = 1'b1;
    wait_cyc(3 * CPB);
    checks++;
    if (frame_err !== 1'b0 || n_ready != 0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored: ferr %b readies %0d lerr %b, expected 0 0 0", frame_err, n_ready, len_err);
    end
    send_header(32'd1);
    send_payload(8'hC3);
    send_payload(8'h00);
    send_payload(8'hFF);
    send_payload(8'h5A);
    wait_cyc(10);
    checks++;
    if (load_done !== 1'b1 || n_ready != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_then_load: done %b readies %0d left %0d, expected 1 4 0",
               load_done, n_ready, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_header(32'd1);
    send_payload(8'h01);
    send_payload(8'h02);
    exp_q.push_back(8'h03);
    fork
      uart_send(8'h03, 1'b1);
      begin
        wait_cyc(5 * CPB);
        checks++;
        if (loader_enable !== 1'b1) begin
          errors++;
          $display("FAIL rmid_enable_before: got %b, expected 1", loader_enable);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({loader_data, loader_ready, loader_enable, load_done, frame_err, len_err} !== 13'd0) begin
          errors++;
          $display("FAIL rmid_outputs: data %02h rdy %b en %b done %b ferr %b lerr %b, expected all 0",
                   loader_data, loader_ready, loader_enable, load_done, frame_err, len_err);
        end
      end
    join
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);
    send_header(32'd1);
    send_payload(8'hA1);
    send_payload(8'hB2);
    send_payload(8'hC3);
    send_payload(8'hD4);
    wait_cyc(10);
    checks++;
    if (load_done !== 1'b1 || n_ready != 4 || exp_q.size() != 0 || loader_enable !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reload: done %b readies %0d left %0d en %b, expected 1 4 0 0",
               load_done, n_ready, exp_q.size(), loader_enable);
    end
  endtask

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    #1;
    test_reset();
    test_back_to_back();
    test_zero_count();
    test_len_err();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
